// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control for the 5-stage pipeline.
// Tracks register-use info for EX/MEM/WB and drives the EX operand mux selects and stall.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic [REG_W-1:0] id_dst_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  input  logic             flush_i,
  output logic [1:0]       fwd_a_sel_o,
  output logic [1:0]       fwd_b_sel_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // Shadow pipeline registers; MEM-stage load flag is not needed since MEM forwarding is source-agnostic
  logic [REG_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_dst_q, ex_dst_d;
  logic             ex_rw_q, ex_rw_d, ex_mr_q, ex_mr_d, ex_v_q, ex_v_d;
  logic [REG_W-1:0] mem_dst_q, mem_dst_d;
  logic             mem_rw_q, mem_rw_d, mem_v_q, mem_v_d;
  logic [REG_W-1:0] wb_dst_q, wb_dst_d;
  logic             wb_rw_q, wb_rw_d, wb_v_q, wb_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mem_fwd_ok, wb_fwd_ok, ex_load_ok, bubble;

  assign mem_fwd_ok = mem_v_q & mem_rw_q & (mem_dst_q != '0);
  assign wb_fwd_ok  = wb_v_q & wb_rw_q & (wb_dst_q != '0);
  assign ex_load_ok = ex_v_q & ex_mr_q & (ex_dst_q != '0);

  // Operand selects: the MEM-stage producer is the most recent, so it wins over WB
  always_comb begin
    fwd_a_sel_o = SEL_REG;
    fwd_b_sel_o = SEL_REG;
    if (mem_fwd_ok && (mem_dst_q == ex_rs_q)) begin
      fwd_a_sel_o = SEL_MEM;
    end else if (wb_fwd_ok && (wb_dst_q == ex_rs_q)) begin
      fwd_a_sel_o = SEL_WB;
    end
    if (mem_fwd_ok && (mem_dst_q == ex_rt_q)) begin
      fwd_b_sel_o = SEL_MEM;
    end else if (wb_fwd_ok && (wb_dst_q == ex_rt_q)) begin
      fwd_b_sel_o = SEL_WB;
    end
  end

  // A taken branch squashes the ID instruction, so it never stalls
  assign stall_o = ex_load_ok & !flush_i &
                   ((id_uses_rs_i & (ex_dst_q == id_rs_i)) |
                    (id_uses_rt_i & (ex_dst_q == id_rt_i)));

  assign bubble      = stall_o | flush_i;
  assign stall_cnt_o = cnt_q;

  always_comb begin
    ex_rs_d   = id_rs_i;
    ex_rt_d   = id_rt_i;
    ex_dst_d  = id_dst_i;
    ex_rw_d   = id_regwrite_i;
    ex_mr_d   = id_memread_i;
    ex_v_d    = 1'b1;
    mem_dst_d = ex_dst_q;
    mem_rw_d  = ex_rw_q;
    mem_v_d   = ex_v_q;
    wb_dst_d  = mem_dst_q;
    wb_rw_d   = mem_rw_q;
    wb_v_d    = mem_v_q;
    cnt_d     = cnt_q;
    if (bubble) begin
      ex_rs_d  = '0;
      ex_rt_d  = '0;
      ex_dst_d = '0;
      ex_rw_d  = 1'b0;
      ex_mr_d  = 1'b0;
      ex_v_d   = 1'b0;
    end
    if (stall_o && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_rs_q   <= '0;
      ex_rt_q   <= '0;
      ex_dst_q  <= '0;
      ex_rw_q   <= 1'b0;
      ex_mr_q   <= 1'b0;
      ex_v_q    <= 1'b0;
      mem_dst_q <= '0;
      mem_rw_q  <= 1'b0;
      mem_v_q   <= 1'b0;
      wb_dst_q  <= '0;
      wb_rw_q   <= 1'b0;
      wb_v_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ex_rs_q   <= ex_rs_d;
      ex_rt_q   <= ex_rt_d;
      ex_dst_q  <= ex_dst_d;
      ex_rw_q   <= ex_rw_d;
      ex_mr_q   <= ex_mr_d;
      ex_v_q    <= ex_v_d;
      mem_dst_q <= mem_dst_d;
      mem_rw_q  <= mem_rw_d;
      mem_v_q   <= mem_v_d;
      wb_dst_q  <= wb_dst_d;
      wb_rw_q   <= wb_rw_d;
      wb_v_q    <= wb_v_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Randomized bench for fwd_hazard_ctrl against an instruction-history reference model.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs, rt, dst;
  logic       rw, mr, urs, urt, fl;
  logic [1:0] fa, fb, fa2, fb2;
  logic       st, st2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .id_rs_i(rs), .id_rt_i(rt), .id_dst_i(dst),
    .id_regwrite_i(rw), .id_memread_i(mr), .id_uses_rs_i(urs), .id_uses_rt_i(urt),
    .flush_i(fl), .fwd_a_sel_o(fa), .fwd_b_sel_o(fb), .stall_o(st), .stall_cnt_o(cnt)
  );

  fwd_hazard_ctrl #(.REG_W(5), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .id_rs_i(rs), .id_rt_i(rt), .id_dst_i(dst),
    .id_regwrite_i(rw), .id_memread_i(mr), .id_uses_rs_i(urs), .id_uses_rt_i(urt),
    .flush_i(fl), .fwd_a_sel_o(fa2), .fwd_b_sel_o(fb2), .stall_o(st2), .stall_cnt_o(cnt2)
  );

  // Reference: history of instructions issued into EX; index 0 = EX, 1 = MEM, 2 = WB
  typedef struct {
    logic [4:0] rs, rt, dst;
    bit rw, mr, v;
  } instr_t;

  instr_t hist[3];
  int     m_cnt16, m_cnt2;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_sel(input logic [4:0] src);
    // Youngest older producer of src wins; $zero has no producer
    if (src == 5'd0) return 2'b00;
    for (int k = 1; k <= 2; k++) begin
      if (hist[k].v && hist[k].rw && hist[k].dst == src) return (k == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic bit model_stall();
    bit uses_load;
    if (fl || !hist[0].v || !hist[0].mr || hist[0].dst == 5'd0) return 1'b0;
    uses_load = (urs && rs == hist[0].dst) || (urt && rt == hist[0].dst);
    return uses_load;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) hist[k] = '{default: '0};
    m_cnt16 = 0;
    m_cnt2  = 0;
  endtask

  task automatic model_edge(input bit exp_stall);
    instr_t nxt;
    if (rst) begin
      model_reset();
      return;
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    if (exp_stall || fl) nxt = '{default: '0};
    else nxt = '{rs: rs, rt: rt, dst: dst, rw: rw, mr: mr, v: 1'b1};
    hist[0] = nxt;
    if (exp_stall) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  // Apply one ID-stage cycle, check mid-cycle, then advance the model on the edge
  task automatic step(input logic [4:0] a_rs, input logic [4:0] a_rt, input logic [4:0] a_dst,
                      input bit a_rw, input bit a_mr, input bit a_urs, input bit a_urt,
                      input bit a_fl, input bit a_rst);
    bit exp_st;
    rs = a_rs; rt = a_rt; dst = a_dst; rw = a_rw; mr = a_mr;
    urs = a_urs; urt = a_urt; fl = a_fl; rst = a_rst;
    @(negedge clk);
    exp_st = model_stall();
    check_val("stall", 32'(st), 32'(exp_st));
    check_val("stall_sat", 32'(st2), 32'(exp_st));
    check_val("cnt16", 32'(cnt), 32'(m_cnt16));
    check_val("cnt2", 32'(cnt2), 32'(m_cnt2));
    // Select of a bubble in EX is don't-care unless nothing older can forward
    if (hist[0].v || (!hist[1].v && !hist[2].v)) begin
      check_val("fwd_a", 32'(fa), 32'(model_sel(hist[0].rs)));
      check_val("fwd_b", 32'(fb), 32'(model_sel(hist[0].rt)));
    end
    @(posedge clk);
    model_edge(exp_st);
    #1;
  endtask

  initial begin
    rst = 1'b1; rs = '0; rt = '0; dst = '0; rw = 1'b0; mr = 1'b0;
    urs = 1'b0; urt = 1'b0; fl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // add $3,$1,$2 ; sub $4,$3,$5 -> A=10
    step(5'd1, 5'd2, 5'd3, 1, 0, 1, 1, 0, 0);
    step(5'd3, 5'd5, 5'd4, 1, 0, 1, 1, 0, 0);
    // add $3 ; nop ; or $6,$7,$3 -> B=01
    step(5'd1, 5'd2, 5'd3, 1, 0, 1, 1, 0, 0);
    step(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    step(5'd7, 5'd3, 5'd6, 1, 0, 1, 1, 0, 0);
    step(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    // lw $2,0($1) ; add $4,$2,$2 held for the stall cycle
    step(5'd1, 5'd0, 5'd2, 1, 1, 1, 0, 0, 0);
    step(5'd2, 5'd2, 5'd4, 1, 0, 1, 1, 0, 0);
    step(5'd2, 5'd2, 5'd4, 1, 0, 1, 1, 0, 0);
    step(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    // Writes to $0, lw $0 and $0 readers
    step(5'd1, 5'd2, 5'd0, 1, 0, 1, 1, 0, 0);
    step(5'd1, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0);
    step(5'd0, 5'd0, 5'd5, 1, 0, 1, 1, 0, 0);
    step(5'd0, 5'd0, 5'd5, 1, 0, 1, 1, 0, 0);
    // Flush while lw-use holds
    step(5'd1, 5'd0, 5'd2, 1, 1, 1, 0, 0, 0);
    step(5'd2, 5'd2, 5'd4, 1, 0, 1, 1, 1, 0);
    step(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    // Reset asserted in the stall cycle
    step(5'd1, 5'd0, 5'd2, 1, 1, 1, 0, 0, 0);
    step(5'd2, 5'd2, 5'd4, 1, 0, 1, 1, 0, 1);
    step(5'd2, 5'd2, 5'd4, 1, 0, 1, 1, 0, 0);

    // Random traffic on a small register set to provoke frequent hazards
    for (int i = 0; i < 3000; i++) begin
      bit r_rw, r_mr;
      r_rw = ($urandom_range(0, 9) < 7);
      r_mr = r_rw && ($urandom_range(0, 9) < 4);
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           r_rw, r_mr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
